divider_result_checker: RTL and testbench

Sequential reconstruction unit for the array-divider error-evaluation flow. It takes one divider result (quotient `q`, remainder `r`), the divisor `d` and the original dividend `n_ref`. It rebuilds the dividend as `q*d + r` with an LSB-first shift-add multiplier and reports the absolute reconstruction error. It also keeps running sample and error totals, so the mean absolute error of an approximate divider can be read out directly.

---
 rtl/divider_result_checker.sv | 136 +++++++++++++
 tb/tb_divider_result_checker.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/divider_result_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// divider_result_checker: rebuilds q*d + r by LSB-first shift-add, reports
// |n_rec - n_ref| and keeps saturating sample/error totals.      Rev 1.0
// ----------------------------------------------------------------------------
module divider_result_checker #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     q_i,
  input  logic [WIDTH-1:0]     d_i,
  input  logic [WIDTH-1:0]     r_i,
  input  logic [2*WIDTH-1:0]   n_ref_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [2*WIDTH-1:0]   n_rec_o,
  output logic [2*WIDTH-1:0]   err_abs_o,
  output logic                 mismatch_o,
  output logic                 dz_o,
  input  logic                 stat_clr_i,
  output logic [31:0]          sample_cnt_o,
  output logic [31:0]          err_sum_o
);

  localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   q_q, d_q;
  logic [2*WIDTH-1:0] nref_q, acc_q;
  logic [SW-1:0]      step_q;
  logic               out_valid_q, mismatch_q, dz_q;
  logic [2*WIDTH-1:0] n_rec_q, err_abs_q;
  logic [31:0]        sample_cnt_q, err_sum_q;

  logic               accept;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] err_val;
  logic [32:0]        sum_ext;

  assign accept  = in_valid_i && in_ready_o;
  assign addend  = {{WIDTH{1'b0}}, d_q} << step_q;
  assign err_val = (acc_q >= nref_q) ? (acc_q - nref_q) : (nref_q - acc_q);
  assign sum_ext = {1'b0, err_sum_q} + 33'(err_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_MUL;
      S_MUL:   if (step_q == STEP_LAST) state_d = S_CMP;
      S_CMP:   state_d = S_DONE;
      S_DONE:  if (out_valid_q && out_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = (state_q == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q          <= '0;
      d_q          <= '0;
      nref_q       <= '0;
      acc_q        <= '0;
      step_q       <= '0;
      out_valid_q  <= 1'b0;
      n_rec_q      <= '0;
      err_abs_q    <= '0;
      mismatch_q   <= 1'b0;
      dz_q         <= 1'b0;
      sample_cnt_q <= '0;
      err_sum_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            q_q    <= q_i;
            d_q    <= d_i;
            nref_q <= n_ref_i;
            acc_q  <= {{WIDTH{1'b0}}, r_i};
            step_q <= '0;
          end
        end
        S_MUL: begin
          if (q_q[step_q]) acc_q <= acc_q + addend;
          step_q <= step_q + 1'b1;
        end
        S_CMP: begin
          n_rec_q     <= acc_q;
          err_abs_q   <= err_val;
          mismatch_q  <= (err_val != '0);
          dz_q        <= (d_q == '0);
          out_valid_q <= 1'b1;
        end
        S_DONE: begin
          if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
        end
        default: ;
      endcase

      // A clear on the CMP edge wins: that sample is dropped from the totals.
      if (stat_clr_i) begin
        sample_cnt_q <= '0;
        err_sum_q    <= '0;
      end else if (state_q == S_CMP) begin
        sample_cnt_q <= (sample_cnt_q == 32'hFFFF_FFFF) ? sample_cnt_q : sample_cnt_q + 32'd1;
        err_sum_q    <= sum_ext[32] ? 32'hFFFF_FFFF : sum_ext[31:0];
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign n_rec_o      = n_rec_q;
  assign err_abs_o    = err_abs_q;
  assign mismatch_o   = mismatch_q;
  assign dz_o         = dz_q;
  assign sample_cnt_o = sample_cnt_q;
  assign err_sum_o    = err_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_divider_result_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_divider_result_checker: directed self-checking bench.        Rev 1.0
// ----------------------------------------------------------------------------
module tb_divider_result_checker;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   q = '0, d = '0, r = '0;
  logic [2*WIDTH-1:0] n_ref = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [2*WIDTH-1:0] n_rec, err_abs;
  logic               mismatch, dz;
  logic               stat_clr = 1'b0;
  logic [31:0]        sample_cnt, err_sum;

  int tests = 0;
  int fails = 0;

  divider_result_checker #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .q_i          (q),
    .d_i          (d),
    .r_i          (r),
    .n_ref_i      (n_ref),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .n_rec_o      (n_rec),
    .err_abs_o    (err_abs),
    .mismatch_o   (mismatch),
    .dz_o         (dz),
    .stat_clr_i   (stat_clr),
    .sample_cnt_o (sample_cnt),
    .err_sum_o    (err_sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then scramble the inputs so only the
  // captured values can produce the right answer.
  task automatic accept(input logic [7:0] qq, input logic [7:0] dd,
                        input logic [7:0] rr, input logic [15:0] nn);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    q = qq; d = dd; r = rr; n_ref = nn; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    q = 8'hA5; d = 8'h5A; r = 8'h3C; n_ref = 16'hBEEF;
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
  endtask

  task automatic wait_result(input int exp_lat);
    int lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("out_valid_after_hs", 64'(out_valid), 64'd0);
    check("in_ready_after_hs", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int seen;

    // Asynchronous reset asserted mid-cycle
    #12 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_n_rec", 64'(n_rec), 64'd0);
    check("rst_err_abs", 64'(err_abs), 64'd0);
    check("rst_flags", 64'({mismatch, dz}), 64'd0);
    check("rst_sample_cnt", 64'(sample_cnt), 64'd0);
    check("rst_err_sum", 64'(err_sum), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_out_valid", 64'(out_valid), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_sample_cnt", 64'(sample_cnt), 64'd0);

    // Exact reconstruction: 12*10 + 5 = 125
    accept(8'h0C, 8'h0A, 8'h05, 16'h007D);
    wait_result(WIDTH + 1);
    check("exact_n_rec", 64'(n_rec), 64'h007D);
    check("exact_err_abs", 64'(err_abs), 64'h0000);
    check("exact_mismatch", 64'(mismatch), 64'd0);
    check("exact_dz", 64'(dz), 64'd0);
    handshake();

    // Extremes: 255*255 + 255 = 0xFF00, with 5 cycles of backpressure
    accept(8'hFF, 8'hFF, 8'hFF, 16'h0000);
    wait_result(WIDTH + 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      check("bp_n_rec", 64'(n_rec), 64'hFF00);
      check("bp_err_abs", 64'(err_abs), 64'hFF00);
    end
    check("ext_mismatch", 64'(mismatch), 64'd1);
    check("ext_dz", 64'(dz), 64'd0);
    handshake();

    // Error of 3: 1*1 + 0 = 1 vs 4
    accept(8'h01, 8'h01, 8'h00, 16'h0004);
    wait_result(WIDTH + 1);
    check("e3_n_rec", 64'(n_rec), 64'h0001);
    check("e3_err_abs", 64'(err_abs), 64'h0003);
    check("stat_cnt3", 64'(sample_cnt), 64'd3);
    check("stat_sum3", 64'(err_sum), 64'h0000FF03);
    handshake();

    // Zero divisor, with stat_clr on its CMP edge (E9)
    accept(8'h12, 8'h00, 8'h07, 16'h0009);
    repeat (WIDTH) tick();
    check("pre_cmp_out_valid", 64'(out_valid), 64'd0);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("dz_out_valid", 64'(out_valid), 64'd1);
    check("dz_n_rec", 64'(n_rec), 64'h0007);
    check("dz_err_abs", 64'(err_abs), 64'h0002);
    check("dz_flag", 64'(dz), 64'd1);
    check("dz_mismatch", 64'(mismatch), 64'd1);
    check("clr_sample_cnt", 64'(sample_cnt), 64'd0);
    check("clr_err_sum", 64'(err_sum), 64'd0);
    handshake();

    // Reset in the middle of MUL
    accept(8'h0C, 8'h0A, 8'h05, 16'h0000);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (out_valid) seen = 1;
    end
    check("mid_rst_no_output", 64'(seen), 64'd0);
    check("mid_rst_cnt", 64'(sample_cnt), 64'd0);
    check("mid_rst_sum", 64'(err_sum), 64'd0);
    check("mid_rst_in_ready_idle", 64'(in_ready), 64'd1);

    // Recovery sample
    accept(8'h0C, 8'h0A, 8'h05, 16'h0080);
    wait_result(WIDTH + 1);
    check("rec_n_rec", 64'(n_rec), 64'h007D);
    check("rec_err_abs", 64'(err_abs), 64'h0003);
    check("rec_cnt", 64'(sample_cnt), 64'd1);
    check("rec_sum", 64'(err_sum), 64'd3);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
